// File: rtl/rng_key_ctrl.sv
// rng_key_ctrl: seeds an external byte RNG, discards its warm-up output, then
// collects 32 sampled bytes into a 256-bit key while running a repetition
// health test. A stuck generator aborts the run and zeroizes the key.
module rng_key_ctrl #(
  parameter int WARMUP_CYCLES = 16,
  parameter int SAMPLE_DIV    = 4,
  parameter int STUCK_LIMIT   = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_clear,
  input  logic [31:0]  i_seed,
  input  logic [7:0]   i_rng_data,
  output logic [31:0]  o_rng_seed,
  output logic         o_rng_reset_n,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_key_valid,
  output logic         o_error,
  output logic [255:0] o_key
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEED    = 3'd1;
  localparam logic [2:0] S_WARMUP  = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W  = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT) : 1;

  logic [2:0]        state;
  logic [WARM_W-1:0] warm_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        byte_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [7:0]        prev_byte;

  logic              sample_now;
  logic              same_byte;
  logic              stuck;
  logic [5:0]        byte_nxt;
  logic              last_byte;

  // Sample strobe, repetition detection and end-of-key detection.
  always_comb begin
    sample_now = (state == S_COLLECT) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    // The first byte of a run has no predecessor, so it never counts as a repeat.
    same_byte  = (byte_cnt != 6'd0) && (i_rng_data == prev_byte);
    // rep_cnt holds repeats so far; one more repeat reaches STUCK_LIMIT identical samples.
    stuck      = sample_now && same_byte && (rep_cnt == REP_W'(STUCK_LIMIT - 2));
    byte_nxt   = byte_cnt + 6'd1;
    last_byte  = sample_now && (byte_nxt == 6'd32);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      warm_cnt      <= '0;
      div_cnt       <= '0;
      byte_cnt      <= '0;
      rep_cnt       <= '0;
      prev_byte     <= '0;
      o_rng_seed    <= '0;
      o_rng_reset_n <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_key_valid   <= 1'b0;
      o_error       <= 1'b0;
      o_key         <= '0;
    end else if (i_clear) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      div_cnt     <= '0;
      byte_cnt    <= '0;
      rep_cnt     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_key_valid <= 1'b0;
      o_error     <= 1'b0;
      o_key       <= '0;
      // Aborting SEED still releases the generator; otherwise the level is kept,
      // so a never-seeded generator stays in reset.
      if (state == S_SEED) o_rng_reset_n <= 1'b1;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            state         <= S_SEED;
            o_rng_seed    <= i_seed;
            o_rng_reset_n <= 1'b0;
            o_busy        <= 1'b1;
            o_key         <= '0;
            o_key_valid   <= 1'b0;
            o_error       <= 1'b0;
            warm_cnt      <= '0;
            div_cnt       <= '0;
            byte_cnt      <= '0;
            rep_cnt       <= '0;
          end
        end
        S_SEED: begin
          state         <= S_WARMUP;
          o_rng_reset_n <= 1'b1;
          warm_cnt      <= '0;
        end
        S_WARMUP: begin
          if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
            state   <= S_COLLECT;
            div_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          if (sample_now) begin
            div_cnt   <= '0;
            prev_byte <= i_rng_data;
            byte_cnt  <= byte_nxt;
            rep_cnt   <= same_byte ? rep_cnt + 1'b1 : '0;
            if (stuck) begin
              state   <= S_FAIL;
              o_busy  <= 1'b0;
              o_error <= 1'b1;
              o_key   <= '0;
            end else begin
              o_key <= {o_key[247:0], i_rng_data};
              if (last_byte) begin
                state       <= S_DONE;
                o_busy      <= 1'b0;
                o_key_valid <= 1'b1;
                o_done      <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_key_ctrl.sv
// tb_rng_key_ctrl: directed and randomized key runs checked against a
// byte-list reference model of key assembly and the repetition health test.
module tb_rng_key_ctrl;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int SL = 8;
  localparam int DONE_N = 1 + W + 32 * D;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic         i_start;
  logic         i_clear;
  logic [31:0]  i_seed;
  logic [7:0]   i_rng_data;
  logic [31:0]  o_rng_seed;
  logic         o_rng_reset_n;
  logic         o_busy;
  logic         o_done;
  logic         o_key_valid;
  logic         o_error;
  logic [255:0] o_key;

  int total = 0;
  int bad   = 0;
  logic [7:0] bytes [32];

  always #5 i_clk = ~i_clk;

  rng_key_ctrl #(.WARMUP_CYCLES(W), .SAMPLE_DIV(D), .STUCK_LIMIT(SL)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_clear(i_clear),
    .i_seed(i_seed), .i_rng_data(i_rng_data), .o_rng_seed(o_rng_seed),
    .o_rng_reset_n(o_rng_reset_n), .o_busy(o_busy), .o_done(o_done),
    .o_key_valid(o_key_valid), .o_error(o_error), .o_key(o_key)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Number of the sample that trips the health test (1-based), 0 if none.
  function automatic int model_fail();
    int run;
    run = 1;
    for (int j = 1; j < 32; j++) begin
      if (bytes[j] == bytes[j-1]) run++;
      else run = 1;
      if (run >= SL) return j + 1;
    end
    return 0;
  endfunction

  function automatic logic [255:0] model_key();
    logic [255:0] k;
    k = '0;
    for (int j = 0; j < 32; j++) k[255 - 8*j -: 8] = bytes[j];
    return k;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " seed"},  256'(o_rng_seed), 256'd0);
    check({tag, " rrst"},  256'(o_rng_reset_n), 256'd0);
    check({tag, " busy"},  256'(o_busy), 256'd0);
    check({tag, " done"},  256'(o_done), 256'd0);
    check({tag, " valid"}, 256'(o_key_valid), 256'd0);
    check({tag, " err"},   256'(o_error), 256'd0);
    check({tag, " key"},   o_key, 256'd0);
  endtask

  // One key request; edge n counts clock edges after the edge sampling i_start.
  task automatic run_key(input string tag, input logic [31:0] seed,
                         input int clear_at, input int start2_at);
    int f, end_n;
    bit cleared, failed;
    f = model_fail();
    failed  = (f != 0);
    cleared = (clear_at > 0) && (!failed || clear_at < 1 + W + D*f);
    if (cleared) begin
      end_n = clear_at;
      failed = 1'b0;
    end else if (failed) end_n = 1 + W + D*f;
    else end_n = DONE_N;

    @(negedge i_clk);
    i_seed  = seed;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_seed  = $urandom;
    check({tag, " seed latched"}, 256'(o_rng_seed), 256'(seed));
    check({tag, " rrst in SEED"}, 256'(o_rng_reset_n), 256'd0);
    check({tag, " busy in SEED"}, 256'(o_busy), 256'd1);
    check({tag, " key cleared"}, o_key, 256'd0);
    check({tag, " valid cleared"}, 256'(o_key_valid), 256'd0);
    check({tag, " err cleared"}, 256'(o_error), 256'd0);

    for (int n = 1; n <= DONE_N + 15; n++) begin
      if (n >= 2 + W && n <= 1 + W + 32*D) i_rng_data = bytes[(n - 2 - W) / D];
      else i_rng_data = 8'($urandom);
      i_start = (n == start2_at) || (n == clear_at);
      i_clear = (n == clear_at);
      @(negedge i_clk);
      i_start = 1'b0;
      i_clear = 1'b0;
      check($sformatf("%s busy n=%0d", tag, n), 256'(o_busy), 256'(n < end_n));
      check($sformatf("%s done n=%0d", tag, n), 256'(o_done),
            256'(!cleared && !failed && n == end_n));
      check($sformatf("%s rrst n=%0d", tag, n), 256'(o_rng_reset_n), 256'd1);
    end

    check({tag, " seed held"}, 256'(o_rng_seed), 256'(seed));
    check({tag, " key"}, o_key, (cleared || failed) ? 256'd0 : model_key());
    check({tag, " valid"}, 256'(o_key_valid), 256'(!cleared && !failed));
    check({tag, " err"}, 256'(o_error), 256'(failed));
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_start    = 1'b0;
    i_clear    = 1'b0;
    i_seed     = 32'h0;
    i_rng_data = 8'h0;
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_rng_data = 8'($urandom);
      @(negedge i_clk);
      check($sformatf("idle rrst c=%0d", c), 256'(o_rng_reset_n), 256'd0);
      check($sformatf("idle busy c=%0d", c), 256'(o_busy), 256'd0);
    end

    // Ascending bytes 0x01..0x20.
    for (int j = 0; j < 32; j++) bytes[j] = 8'(j + 1);
    run_key("ascend", 32'h12345678, 0, 0);

    // Stuck generator.
    for (int j = 0; j < 32; j++) bytes[j] = 8'hAA;
    run_key("stuck", 32'hCAFEF00D, 0, 0);

    // Seven repeats then a break, repeating: just under the limit.
    for (int j = 0; j < 32; j++) bytes[j] = (j % 8 == 7) ? 8'h56 : 8'h55;
    run_key("pattern", 32'h0BADBEEF, 0, 0);

    // Clear together with start at byte 10 of collection.
    for (int j = 0; j < 32; j++) bytes[j] = 8'(j + 1);
    run_key("clear", 32'h11112222, 1 + W + D*10, 0);

    // Second start during warm-up is ignored.
    for (int j = 0; j < 32; j++) bytes[j] = 8'($urandom);
    bytes[1] = ~bytes[0];
    run_key("start2", 32'h5A5A0001, 0, 6);

    // Eight identical bytes ending on the final sample.
    for (int j = 0; j < 32; j++) bytes[j] = 8'(j);
    for (int j = 24; j < 32; j++) bytes[j] = 8'hEE;
    run_key("stuck_last", 32'h00C0FFEE, 0, 0);

    // Randomized runs, some drawn from a tiny alphabet to provoke stuck runs.
    for (int r = 0; r < 6; r++) begin
      int p;
      for (int j = 0; j < 32; j++)
        bytes[j] = (r % 2 == 1) ? 8'($urandom_range(0, 1)) : 8'($urandom);
      if (r == 4) begin
        p = $urandom_range(1, 24);
        for (int j = p; j < p + SL; j++) bytes[j] = bytes[p-1] ^ 8'h80;
      end
      run_key($sformatf("rand%0d", r), $urandom, 0, 0);
    end

    // Reset in the middle of collection.
    for (int j = 0; j < 32; j++) bytes[j] = 8'(3*j + 1);
    @(negedge i_clk);
    i_seed  = 32'hDEAD0001;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (n >= 2 + W) i_rng_data = bytes[(n - 2 - W) / D];
      @(negedge i_clk);
    end
    check("mid busy", 256'(o_busy), 256'd1);
    #2 i_reset_n = 1'b0;
    #1 check_reset_values("async reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      i_rng_data = 8'($urandom);
      @(negedge i_clk);
      check($sformatf("post rrst c=%0d", c), 256'(o_rng_reset_n), 256'd0);
      check($sformatf("post done c=%0d", c), 256'(o_done), 256'd0);
      check($sformatf("post busy c=%0d", c), 256'(o_busy), 256'd0);
    end
    check_reset_values("post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
